// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx and its consumer.
// The receiver owns data/valid/status; the consumer owns ready.
interface uart_rx_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      output data,
      output valid,
      output frame_err,
      output overrun,
      output busy,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      input  frame_err,
      input  overrun,
      input  busy,
      output ready
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at half a bit, mid-bit
// data sampling, one-deep holding register with overrun/frame errors.
module uart_rx #(
   parameter int BAUD        = 9_600,
   parameter int INPUT_CLOCK = 16_000_000
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      i_rx,
   uart_rx_if.master bus
);

   localparam int CLOCKS_PER_BAUD = INPUT_CLOCK / BAUD;
   localparam int HALF_BAUD       = CLOCKS_PER_BAUD / 2;

   localparam logic [12:0] FULL_M1 = 13'(CLOCKS_PER_BAUD - 1);
   localparam logic [12:0] HALF_M1 = 13'(HALF_BAUD - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t      state;
   logic [1:0]  sync;
   logic [12:0] cnt;
   logic [2:0]  idx;
   logic [7:0]  shift;
   logic        rx_s;

   assign rx_s = sync[1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         sync          <= 2'b11;
         cnt           <= '0;
         idx           <= '0;
         shift         <= '0;
         bus.data      <= 8'h00;
         bus.valid     <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.overrun   <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         sync          <= {sync[0], i_rx};
         bus.frame_err <= 1'b0;
         bus.overrun   <= 1'b0;
         if (bus.valid && bus.ready)
            bus.valid <= 1'b0;

         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state    <= START;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
               end
            end

            START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  idx <= '0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     // line went back high: treat as noise
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 13'd1;
               end
            end

            DATA: begin
               if (cnt == FULL_M1) begin
                  cnt   <= '0;
                  shift <= {rx_s, shift[7:1]};
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7)
                     state <= STOP;
               end else begin
                  cnt <= cnt + 13'd1;
               end
            end

            STOP: begin
               if (cnt == FULL_M1) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                     // a same-edge accept frees the holding register
                     if (!bus.valid || bus.ready) begin
                        bus.data  <= shift;
                        bus.valid <= 1'b1;
                     end else begin
                        bus.overrun <= 1'b1;
                     end
                  end else begin
                     state         <= WAIT_HIGH;
                     bus.frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 13'd1;
               end
            end

            WAIT_HIGH: begin
               if (rx_s) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end

            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
